// File: rtl/fir_io_pkg.sv
// rtl/fir_io_pkg.sv - shared constants and state encoding for the FIR tile pin driver
// Contents: default sample/result widths, io_in pin indices, driver FSM states.
package fir_io_pkg;

    localparam int BW_IN_DEFAULT  = 6;
    localparam int BW_OUT_DEFAULT = 8;

    localparam int IO_CLK_BIT = 0;
    localparam int IO_RST_BIT = 1;
    localparam int IO_X_LSB   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/dut_clk_gen.sv
// rtl/dut_clk_gen.sv - phase counter that synthesises the tile clock pin from the system clock
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   clear             force phase 0 (clock pin low) next cycle
//   hold              freeze the phase (only used while sitting at phase 0)
//   dut_clk           registered tile clock, high for phases CLK_DIV/2..CLK_DIV-1
//   last_phase        current phase is CLK_DIV-1
//   wrap              phase returns to 0 next cycle
//   phase_zero        current phase is 0
module dut_clk_gen
    import fir_io_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic hold,
    output logic dut_clk,
    output logic last_phase,
    output logic wrap,
    output logic phase_zero
);

    localparam int            PW      = $clog2(CLK_DIV);
    localparam logic [PW-1:0] HALF_M1 = PW'(CLK_DIV / 2 - 1);
    localparam logic [PW-1:0] LAST    = PW'(CLK_DIV - 1);

    logic [PW-1:0] ph_q, ph_d;
    logic          clk_q, clk_d;
    logic          rise_next;

    assign rise_next  = (ph_q == HALF_M1);
    assign last_phase = (ph_q == LAST);
    assign phase_zero = (ph_q == '0);
    assign wrap       = last_phase & ~clear;
    assign dut_clk    = clk_q;

    // The clock pin is tracked incrementally so it always equals (ph >= CLK_DIV/2)
    // one register stage later, without a comparator on the next phase value.
    always_comb begin
        ph_d  = ph_q;
        clk_d = clk_q;
        if (clear) begin
            ph_d  = '0;
            clk_d = 1'b0;
        end else if (!hold) begin
            ph_d = last_phase ? '0 : ph_q + 1'b1;
            if (rise_next) begin
                clk_d = 1'b1;
            end else if (last_phase) begin
                clk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q  <= '0;
            clk_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            clk_q <= clk_d;
        end
    end

endmodule

// File: rtl/fir_io_driver.sv
// rtl/fir_io_driver.sv - host-side driver for the 8-bit FIR/MAC tile pin interface
// Ports:
//   clk, rst                  system clock, asynchronous active-low reset
//   start                     pulse that (re)starts the tile reset sequence
//   s_valid/s_ready/s_data    input sample stream (signed BW_in bits)
//   m_valid/m_ready/m_data    captured tile result stream (BW_out bits)
//   io_in                     tile pins {0.., x, rst, clk}
//   io_out                    tile result pins
//   busy                      high while resetting or running the tile
module fir_io_driver
    import fir_io_pkg::*;
#(
    parameter int BW_in      = BW_IN_DEFAULT,
    parameter int BW_out     = BW_OUT_DEFAULT,
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BW_in-1:0]  s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BW_out-1:0] m_data,
    output logic [7:0]        io_in,
    input  logic [7:0]        io_out,
    output logic              busy
);

    localparam int             RCW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);

    state_t              state_q, state_d;
    logic [RCW-1:0]      rcnt_q, rcnt_d;
    logic [BW_in-1:0]    x_q, x_d;
    logic                rst_pin_q;
    logic                m_valid_q, m_valid_d;
    logic [BW_out-1:0]   m_data_q, m_data_d;

    logic dut_clk, last_phase, wrap, phase_zero;
    logic clear, hold, accept;

    // A new sample is only taken at phase 0 so every accepted sample gets one
    // complete, glitch-free tile clock period; start always takes priority.
    assign s_ready = (state_q == ST_RUN) & phase_zero & (~m_valid_q | m_ready) & ~start;
    assign accept  = s_valid & s_ready;
    assign clear   = start | (state_q == ST_IDLE);
    assign hold    = (state_q == ST_RUN) & phase_zero & ~accept;
    assign busy    = (state_q != ST_IDLE);
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    dut_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst),
        .clear     (clear),
        .hold      (hold),
        .dut_clk   (dut_clk),
        .last_phase(last_phase),
        .wrap      (wrap),
        .phase_zero(phase_zero)
    );

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        x_d       = x_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (m_valid_q & m_ready) begin
            m_valid_d = 1'b0;
        end

        if (start) begin
            state_d   = ST_RESET;
            rcnt_d    = '0;
            x_d       = '0;
            m_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (wrap) begin
                        if (rcnt_q == RC_LAST) begin
                            state_d = ST_RUN;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        x_d = s_data;
                    end
                    // Capture on the last phase overrides a same-cycle consume.
                    if (last_phase) begin
                        m_valid_d = 1'b1;
                        m_data_d  = io_out[BW_out-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rcnt_q    <= '0;
            x_q       <= '0;
            rst_pin_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            x_q       <= x_d;
            rst_pin_q <= (state_d == ST_RESET);
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Every pin comes straight from a flop; unused upper pins stay low.
    always_comb begin
        io_in                     = '0;
        io_in[IO_CLK_BIT]         = dut_clk;
        io_in[IO_RST_BIT]         = rst_pin_q;
        io_in[IO_X_LSB +: BW_in]  = x_q;
    end

endmodule

// File: tb/tb_fir_io_driver.sv
// tb/tb_fir_io_driver.sv - scoreboard bench for fir_io_driver with a behavioural FIR tile on the pins
module tb_fir_io_driver;

    localparam int BW_in      = 6;
    localparam int BW_out     = 8;
    localparam int CLK_DIV    = 4;
    localparam int RST_CYCLES = 2;

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic              start   = 1'b0;
    logic              s_valid = 1'b0;
    logic [BW_in-1:0]  s_data  = '0;
    logic              s_ready;
    logic              m_valid;
    logic              m_ready;
    logic [BW_out-1:0] m_data;
    logic [7:0]        io_in;
    logic [7:0]        io_out  = 8'h00;
    logic              busy;

    logic mr_rand  = 1'b0;
    logic mr_force = 1'b1;
    logic mr_bit   = 1'b0;
    assign m_ready = mr_rand ? mr_bit : mr_force;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] d;
        int         acc;
    } exp_t;
    exp_t exp_q[$];
    int   prev_s = 0;

    fir_io_driver #(
        .BW_in     (BW_in),
        .BW_out    (BW_out),
        .CLK_DIV   (CLK_DIV),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .io_in  (io_in),
        .io_out (io_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        mr_bit = 1'($urandom_range(0, 1));
    end

    // Tile: y = 2*x + x_prev + 0x7B on each rising pin clock, cleared while its reset pin is high.
    logic signed [7:0] tile_prev = 8'sd0;
    logic signed [7:0] tile_x;
    always @(posedge io_in[0]) begin
        tile_x = {{2{io_in[7]}}, io_in[7:2]};
        if (io_in[1]) begin
            tile_prev = 8'sd0;
            io_out    = 8'h00;
        end else begin
            io_out    = tile_x + tile_x + tile_prev + 8'sh7B;
            tile_prev = tile_x;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push_exp(input logic [BW_in-1:0] d);
        int   sv;
        exp_t e;
        sv    = int'($signed(d));
        e.d   = 8'(2 * sv + prev_s + 123);
        e.acc = cyc;
        exp_q.push_back(e);
        prev_s = sv;
    endfunction

    // Monitor: checks each new result against the queue head, pops on consume.
    logic       mv_prev = 1'b0;
    logic [7:0] held    = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            mv_prev = 1'b0;
        end else begin
            if (m_valid && !mv_prev) begin
                chk("result_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("latency", cyc - exp_q[0].acc, CLK_DIV);
                    chk("m_data", m_data, exp_q[0].d);
                end
                held = m_data;
            end
            if (m_valid && m_ready && exp_q.size() > 0) begin
                chk("m_data_stable", m_data, held);
                exp_q.delete(0);
            end
            mv_prev = m_valid;
        end
    end

    // All driver tasks are entered 1 time unit after a rising edge.
    task automatic send(input logic [BW_in-1:0] d);
        bit got = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (s_ready) begin
                got = 1'b1;
                push_exp(d);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("accepted", 32'(got), 1);
    endtask

    task automatic pulse_start();
        logic sv_rand, sv_force;
        sv_rand  = mr_rand;
        sv_force = mr_force;
        mr_rand  = 1'b0;
        mr_force = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.delete();
        prev_s   = 0;
        mr_rand  = sv_rand;
        mr_force = sv_force;
    endtask

    task automatic wait_mvalid(input string nm);
        int n = 0;
        @(negedge clk);
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(m_valid), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [7:0] held_bp;
    int         n_seen;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_io_in", io_in, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_data", m_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_io_in", io_in, 0);
        chk("idle_busy", busy, 0);
        chk("idle_s_ready", s_ready, 0);

        @(posedge clk); #1;
        pulse_start();
        for (int k = 0; k < RST_CYCLES * CLK_DIV; k++) begin
            @(negedge clk);
            chk("reset_pins", io_in, 32'h2 | 32'((k % CLK_DIV) >= CLK_DIV / 2));
        end
        @(negedge clk);
        chk("run_io_in", io_in, 0);
        chk("run_s_ready", s_ready, 1);
        chk("run_busy", busy, 1);

        @(posedge clk); #1;
        send(6'h15);
        @(negedge clk); chk("x_setup", io_in, 8'h54);
        @(negedge clk); chk("x_clk_hi", io_in, 8'h55);
        @(negedge clk); chk("x_clk_hi2", io_in, 8'h55);
        @(negedge clk);
        chk("first_valid", m_valid, 1);
        chk("first_data", m_data, 8'hA5);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("pause_io_in", io_in, 8'h54);
        end
        chk("pause_no_valid", m_valid, 0);

        @(posedge clk); #1;
        mr_force = 1'b0;
        send(6'h2A);
        wait_mvalid("bp_first_valid");
        held_bp = m_data;
        @(posedge clk); #1;
        s_data  = 6'h0F;
        s_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_dut_clk", io_in[0], 0);
            chk("bp_m_data", m_data, held_bp);
        end
        @(posedge clk); #1;
        mr_force = 1'b1;
        @(negedge clk);
        chk("bp_release_accept", s_ready, 1);
        if (s_ready) push_exp(6'h0F);
        @(posedge clk); #1;
        s_valid = 1'b0;

        mr_force = 1'b0;
        wait_mvalid("abort_pending_valid");
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_rst_pin", io_in[1], 1);

        mr_force = 1'b1;
        @(posedge clk); #1;
        send(6'h33);
        @(posedge clk); #1;
        pulse_start();
        n_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (m_valid) n_seen++;
        end
        chk("abort_no_result", n_seen, 0);

        @(posedge clk); #1;
        mr_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            if ($urandom_range(0, 24) == 0) pulse_start();
            send(6'($urandom));
        end

        mr_rand  = 1'b0;
        mr_force = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        chk("drained", exp_q.size(), 0);

        @(posedge clk); #1;
        mr_force = 1'b0;
        send(6'h3C);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_io_in", io_in, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_ready", s_ready, 0);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_data", m_data, 0);
        exp_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
